thunderbird_lamp_monitor: RTL and testbench
===========================================

THUNDERBIRD_LAMP_MONITOR -- requirements
Module: thunderbird_lamp_monitor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have ports la, lb, lc, input, 1 bit each: observed left lamp lines; pattern written {la,lb,lc}.
REQ-004 SHALL have ports ra, rb, rc, input, 1 bit each: observed right lamp lines; pattern written {ra,rb,rc}.
REQ-005 SHALL have port clr, input, 1 bit: synchronous clear of error flags and cycle counters.
REQ-006 SHALL have ports left_active and right_active, output, 1 bit each: side is mid-sequence.
REQ-007 SHALL have port hazard, output, 1 bit: both sides are mid-sequence.
REQ-008 SHALL have ports left_err and right_err, output, 1 bit each: sticky illegal-sequence flags.
REQ-009 SHALL have ports left_cycles and right_cycles, output, 8 bits each: completed blink sequences per side, saturating.

Function
REQ-010 SHALL sample all six lamp inputs on every rising clk edge; no enable.
REQ-011 SHALL run one independent FSM per side with states IDLE, S1, S2, S3, RESYNC.
REQ-012 SHALL use legal sequence 000 -> 001 -> 011 -> 111 -> 000; one step per clock; a non-zero pattern never holds for two consecutive samples.
REQ-013 SHALL transition IDLE on 000 -> IDLE; on 001 -> S1.
REQ-014 SHALL transition S1 on 011 -> S2; on 000 -> IDLE (abort, no error).
REQ-015 SHALL transition S2 on 111 -> S3; on 000 -> IDLE (abort, no error).
REQ-016 SHALL transition S3 on 000 -> IDLE and count one completed cycle.
REQ-017 SHALL treat every other sampled pattern as illegal in any non-RESYNC state: next state RESYNC, side err set. Covers 010, 100, 101, 110, skips (e.g. 000->011), and repeats (e.g. 001->001).
REQ-018 SHALL keep RESYNC until 000 is sampled, then go to IDLE; no further error set while in RESYNC.
REQ-019 SHALL decode outputs Moore-style from registered state: side_active = state in {S1,S2,S3}; hazard = left_active AND right_active.
REQ-020 SHALL make outputs reflect a sampled pattern from the clock edge that samples it; latency is one edge.
REQ-021 SHALL increment a counter on the edge of S3 -> IDLE; counters are 8-bit unsigned, saturate at 255, never wrap.
REQ-022 SHALL treat an err flag as sticky: set by REQ-017, cleared only by clr or reset.
REQ-023 SHALL, when clr is high on an edge: zero both counters and both err flags; FSMs are not affected.
REQ-024 SHALL give set priority over clr when both occur on the same edge: an illegal pattern or a completion on a clr edge leaves err=1, or counter=1, respectively.
REQ-025 SHALL keep the sides fully independent; activity or errors on one side never alter the other, except hazard.

Reset
REQ-026 SHALL, while reset is high: both FSMs IDLE; all active, hazard, and err outputs 0; both counters 0.
REQ-027 SHALL treat reset asserted mid-sequence as abandoning the sequence with no count and no error; after release, the next sample is evaluated from IDLE.

Verification
REQ-028 SHALL cover: left 000,001,011,111,000 -> left_active 0,1,1,1,0; left_cycles 0->1; left_err 0; right side all 0.
REQ-029 SHALL cover: left and right both running the legal sequence in lockstep -> hazard=1 on the S1/S2/S3 edges only; both counters reach 1.
REQ-030 SHALL cover: right 000,001,001 -> right_err=1 and right_active=0 from the second 001. Then 011,000 -> still RESYNC at 011; IDLE at 000; err stays 1 until clr.
REQ-031 SHALL cover: left 000,001,000 (abort) -> left_active 1 then 0; left_err=0; left_cycles unchanged.
REQ-032 SHALL cover: 256 legal left sequences -> left_cycles=255 (saturated). A completion with clr high on the same edge -> left_cycles=1.
REQ-033 SHALL cover: reset asserted asynchronously between edges while left is in S2 -> all outputs 0 before the next edge. After release, a sampled 111 -> left_err=1.

Source files
------------

// File: rtl/thunderbird_lamp_monitor_if.sv
// Lamp observation bundle: six sampled lamp lines and a clear strobe in,
// per-side activity, hazard, sticky error and completion counters out.
interface thunderbird_lamp_monitor_if;
  logic       la, lb, lc;
  logic       ra, rb, rc;
  logic       clr;
  logic       left_active, right_active;
  logic       hazard;
  logic       left_err, right_err;
  logic [7:0] left_cycles, right_cycles;

  modport master (
    output la, lb, lc, ra, rb, rc, clr,
    input  left_active, right_active, hazard,
    input  left_err, right_err, left_cycles, right_cycles
  );

  modport slave (
    input  la, lb, lc, ra, rb, rc, clr,
    output left_active, right_active, hazard,
    output left_err, right_err, left_cycles, right_cycles
  );
endinterface

// File: rtl/thunderbird_lamp_monitor.sv
// Thunderbird tail-lamp monitor: one sequence checker per side watches the
// 000 -> 001 -> 011 -> 111 -> 000 blink and flags any deviation.

// state  | meaning
// IDLE   | lamps dark, waiting for 001
// S1     | 001 seen, expecting 011 (000 aborts)
// S2     | 011 seen, expecting 111 (000 aborts)
// S3     | 111 seen, expecting 000 to complete a cycle
// RESYNC | illegal pattern seen, waiting for 000
module thunderbird_lamp_side (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] pattern,
  input  logic       clr,
  output logic       active,
  output logic       err,
  output logic [7:0] cycles
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S1     = 3'd1,
    S2     = 3'd2,
    S3     = 3'd3,
    RESYNC = 3'd4
  } state_t;

  localparam logic [2:0] PAT_OFF  = 3'b000;
  localparam logic [2:0] PAT_ONE  = 3'b001;
  localparam logic [2:0] PAT_TWO  = 3'b011;
  localparam logic [2:0] PAT_FULL = 3'b111;
  localparam logic [7:0] CYCLES_MAX = 8'hFF;

  state_t state, state_next;
  logic   illegal;
  logic   done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    illegal    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pattern == PAT_ONE)       state_next = S1;
        else if (pattern != PAT_OFF)  illegal    = 1'b1;
      end
      S1: begin
        if (pattern == PAT_TWO)       state_next = S2;
        else if (pattern == PAT_OFF)  state_next = IDLE;
        else                          illegal    = 1'b1;
      end
      S2: begin
        if (pattern == PAT_FULL)      state_next = S3;
        else if (pattern == PAT_OFF)  state_next = IDLE;
        else                          illegal    = 1'b1;
      end
      S3: begin
        if (pattern == PAT_OFF) begin
          state_next = IDLE;
          done       = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      RESYNC: begin
        if (pattern == PAT_OFF)       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (illegal) state_next = RESYNC;
  end

  // A set event on the same edge as clr wins: err stays 1, counter restarts at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err    <= 1'b0;
      cycles <= 8'd0;
    end else begin
      if (illegal)  err <= 1'b1;
      else if (clr) err <= 1'b0;

      if (done) begin
        if (clr)                       cycles <= 8'd1;
        else if (cycles != CYCLES_MAX) cycles <= cycles + 8'd1;
      end else if (clr) begin
        cycles <= 8'd0;
      end
    end
  end

  assign active = (state == S1) || (state == S2) || (state == S3);
endmodule

module thunderbird_lamp_monitor (
  input logic                         clk,
  input logic                         reset,
  thunderbird_lamp_monitor_if.slave   lamp_if
);
  logic       left_active, right_active;
  logic       left_err, right_err;
  logic [7:0] left_cycles, right_cycles;

  thunderbird_lamp_side u_left (
    .clk     (clk),
    .reset   (reset),
    .pattern ({lamp_if.la, lamp_if.lb, lamp_if.lc}),
    .clr     (lamp_if.clr),
    .active  (left_active),
    .err     (left_err),
    .cycles  (left_cycles)
  );

  thunderbird_lamp_side u_right (
    .clk     (clk),
    .reset   (reset),
    .pattern ({lamp_if.ra, lamp_if.rb, lamp_if.rc}),
    .clr     (lamp_if.clr),
    .active  (right_active),
    .err     (right_err),
    .cycles  (right_cycles)
  );

  assign lamp_if.left_active  = left_active;
  assign lamp_if.right_active = right_active;
  assign lamp_if.hazard       = left_active & right_active;
  assign lamp_if.left_err     = left_err;
  assign lamp_if.right_err    = right_err;
  assign lamp_if.left_cycles  = left_cycles;
  assign lamp_if.right_cycles = right_cycles;
endmodule

// File: tb/tb_thunderbird_lamp_monitor.sv
// Directed bench for the lamp monitor: hand-computed expectations checked
// with immediate assertions after each sampling edge.
module tb_thunderbird_lamp_monitor;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  thunderbird_lamp_monitor_if lamp_if ();

  thunderbird_lamp_monitor dut (
    .clk     (clk),
    .reset   (reset),
    .lamp_if (lamp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic [2:0] l, input logic [2:0] r, input logic c);
    @(negedge clk);
    {lamp_if.la, lamp_if.lb, lamp_if.lc} = l;
    {lamp_if.ra, lamp_if.rb, lamp_if.rc} = r;
    lamp_if.clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic left_seq();
    step(3'b001, 3'b000, 1'b0);
    step(3'b011, 3'b000, 1'b0);
    step(3'b111, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lact"}, {7'd0, lamp_if.left_active}, 8'd0);
    chk({tag, "_ract"}, {7'd0, lamp_if.right_active}, 8'd0);
    chk({tag, "_haz"},  {7'd0, lamp_if.hazard}, 8'd0);
    chk({tag, "_lerr"}, {7'd0, lamp_if.left_err}, 8'd0);
    chk({tag, "_rerr"}, {7'd0, lamp_if.right_err}, 8'd0);
    chk({tag, "_lcyc"}, lamp_if.left_cycles, 8'd0);
    chk({tag, "_rcyc"}, lamp_if.right_cycles, 8'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    {lamp_if.la, lamp_if.lb, lamp_if.lc} = 3'b000;
    {lamp_if.ra, lamp_if.rb, lamp_if.rc} = 3'b000;
    lamp_if.clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single legal left sequence
    step(3'b000, 3'b000, 1'b0); chk("l_seq0_act", {7'd0, lamp_if.left_active}, 8'd0);
    step(3'b001, 3'b000, 1'b0); chk("l_seq1_act", {7'd0, lamp_if.left_active}, 8'd1);
    chk("l_seq1_haz", {7'd0, lamp_if.hazard}, 8'd0);
    step(3'b011, 3'b000, 1'b0); chk("l_seq2_act", {7'd0, lamp_if.left_active}, 8'd1);
    step(3'b111, 3'b000, 1'b0); chk("l_seq3_act", {7'd0, lamp_if.left_active}, 8'd1);
    chk("l_seq3_cyc", lamp_if.left_cycles, 8'd0);
    step(3'b000, 3'b000, 1'b0); chk("l_seq4_act", {7'd0, lamp_if.left_active}, 8'd0);
    chk("l_seq4_cyc", lamp_if.left_cycles, 8'd1);
    chk("l_seq4_err", {7'd0, lamp_if.left_err}, 8'd0);
    chk("l_seq4_ract", {7'd0, lamp_if.right_active}, 8'd0);
    chk("l_seq4_rcyc", lamp_if.right_cycles, 8'd0);
    chk("l_seq4_rerr", {7'd0, lamp_if.right_err}, 8'd0);

    // Both sides in lockstep: hazard only in S1/S2/S3
    step(3'b001, 3'b001, 1'b0); chk("hz1", {7'd0, lamp_if.hazard}, 8'd1);
    step(3'b011, 3'b011, 1'b0); chk("hz2", {7'd0, lamp_if.hazard}, 8'd1);
    step(3'b111, 3'b111, 1'b0); chk("hz3", {7'd0, lamp_if.hazard}, 8'd1);
    step(3'b000, 3'b000, 1'b0); chk("hz4", {7'd0, lamp_if.hazard}, 8'd0);
    chk("hz4_lcyc", lamp_if.left_cycles, 8'd2);
    chk("hz4_rcyc", lamp_if.right_cycles, 8'd1);

    // Right repeat 001 -> RESYNC, sticky error
    step(3'b000, 3'b001, 1'b0); chk("rr1_act", {7'd0, lamp_if.right_active}, 8'd1);
    step(3'b000, 3'b001, 1'b0); chk("rr2_act", {7'd0, lamp_if.right_active}, 8'd0);
    chk("rr2_err", {7'd0, lamp_if.right_err}, 8'd1);
    chk("rr2_lerr", {7'd0, lamp_if.left_err}, 8'd0);
    step(3'b000, 3'b011, 1'b0); chk("rr3_act", {7'd0, lamp_if.right_active}, 8'd0);
    chk("rr3_err", {7'd0, lamp_if.right_err}, 8'd1);
    step(3'b000, 3'b000, 1'b0); chk("rr4_err", {7'd0, lamp_if.right_err}, 8'd1);
    step(3'b000, 3'b001, 1'b0); chk("rr5_act", {7'd0, lamp_if.right_active}, 8'd1);
    step(3'b000, 3'b011, 1'b0);
    step(3'b000, 3'b111, 1'b0);
    step(3'b000, 3'b000, 1'b0); chk("rr8_rcyc", lamp_if.right_cycles, 8'd2);
    chk("rr8_err", {7'd0, lamp_if.right_err}, 8'd1);
    chk("rr8_lcyc", lamp_if.left_cycles, 8'd2);

    // Clear wipes flags and counters
    step(3'b000, 3'b000, 1'b1);
    chk("clr_rerr", {7'd0, lamp_if.right_err}, 8'd0);
    chk("clr_lcyc", lamp_if.left_cycles, 8'd0);
    chk("clr_rcyc", lamp_if.right_cycles, 8'd0);

    // Left abort in S1
    step(3'b001, 3'b000, 1'b0); chk("ab1_act", {7'd0, lamp_if.left_active}, 8'd1);
    step(3'b000, 3'b000, 1'b0); chk("ab2_act", {7'd0, lamp_if.left_active}, 8'd0);
    chk("ab2_err", {7'd0, lamp_if.left_err}, 8'd0);
    chk("ab2_cyc", lamp_if.left_cycles, 8'd0);

    // Saturation
    for (int i = 0; i < 255; i++) left_seq();
    chk("sat255", lamp_if.left_cycles, 8'd255);
    left_seq();
    chk("sat256", lamp_if.left_cycles, 8'd255);
    chk("sat_rcyc", lamp_if.right_cycles, 8'd0);
    chk("sat_err", {7'd0, lamp_if.left_err}, 8'd0);

    // Completion and clr on the same edge
    step(3'b001, 3'b000, 1'b0);
    step(3'b011, 3'b000, 1'b0);
    step(3'b111, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b1); chk("clr_done_cyc", lamp_if.left_cycles, 8'd1);

    // Illegal pattern and clr on the same edge
    step(3'b010, 3'b000, 1'b1); chk("clr_ill_err", {7'd0, lamp_if.left_err}, 8'd1);
    chk("clr_ill_cyc", lamp_if.left_cycles, 8'd0);
    step(3'b000, 3'b000, 1'b0); chk("clr_ill_err2", {7'd0, lamp_if.left_err}, 8'd1);

    // Async reset while left is in S2
    step(3'b001, 3'b000, 1'b0);
    step(3'b011, 3'b000, 1'b0); chk("rst_pre_act", {7'd0, lamp_if.left_active}, 8'd1);
    #2;
    reset = 1'b1;
    {lamp_if.la, lamp_if.lb, lamp_if.lc} = 3'b000;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_post_err", {7'd0, lamp_if.left_err}, 8'd0);
    step(3'b111, 3'b000, 1'b0);
    chk("rst_111_err", {7'd0, lamp_if.left_err}, 8'd1);
    chk("rst_111_act", {7'd0, lamp_if.left_active}, 8'd0);
    chk("rst_111_cyc", lamp_if.left_cycles, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
